pspin_her_sched: RTL

- Shares the single HER generator completion input between NUM_PORTS ingress DMA completion streams.
- Arbitrates round-robin across ports and registers the winner into a one-entry output stage.
- Limits outstanding HERs with an in-flight credit counter, decremented by PsPIN handler-completion feedback.
- Sits between the ingress DMA channels and pspin_her_gen (gen_* interface).

---
 rtl/pspin_her_sched_pkg.sv | 17 +
 rtl/pspin_rr_arb.sv | 54 +++++
 rtl/pspin_her_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pspin_her_sched_pkg.sv
// rtl/pspin_her_sched_pkg.sv - shared width derivations and packed-slice helper for the HER scheduler
package pspin_her_sched_pkg;

    function automatic int cnt_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of element idx in a packed array of width-bit elements, element 0 in LSBs.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/pspin_rr_arb.sv
// rtl/pspin_rr_arb.sv - round-robin arbiter owning its rotating priority pointer
module pspin_rr_arb
    import pspin_her_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr_q) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (int'(grant_idx) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pspin_her_sched.sv
// rtl/pspin_her_sched.sv - credit-limited round-robin sharing of the HER generator completion input
module pspin_her_sched
    import pspin_her_sched_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 20,
    parameter int TAG_WIDTH      = 32,
    parameter int MAX_INFLIGHT   = 64,
    parameter int CNT_WIDTH      = cnt_width(MAX_INFLIGHT)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0]      in_len,
    input  logic [NUM_PORTS*TAG_WIDTH-1:0]      in_tag,
    input  logic [NUM_PORTS-1:0]                in_valid,
    output logic [NUM_PORTS-1:0]                in_ready,
    output logic [AXI_ADDR_WIDTH-1:0]           out_addr,
    output logic [LEN_WIDTH-1:0]                out_len,
    output logic [TAG_WIDTH-1:0]                out_tag,
    output logic                                out_valid,
    input  logic                                out_ready,
    input  logic                                fb_valid,
    input  logic                                conf_enable,
    input  logic [CNT_WIDTH-1:0]                conf_credit_limit,
    output logic [CNT_WIDTH-1:0]                stat_inflight,
    output logic                                stat_underflow
);

    localparam int IW = idx_width(NUM_PORTS);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);

    logic [NUM_PORTS-1:0]      arb_grant;
    logic [IW-1:0]             arb_idx;
    logic                      grant;
    logic                      slot_free;
    logic [CNT_WIDTH-1:0]      eff_limit;
    logic [AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]      sel_len;
    logic [TAG_WIDTH-1:0]      sel_tag;

    logic                      out_valid_q, out_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [LEN_WIDTH-1:0]      out_len_q, out_len_d;
    logic [TAG_WIDTH-1:0]      out_tag_q, out_tag_d;
    logic [CNT_WIDTH-1:0]      inflight_q, inflight_d;
    logic                      underflow_q, underflow_d;

    pspin_rr_arb #(.N(NUM_PORTS), .IW(IW)) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (in_valid),
        .advance   (grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        eff_limit = (conf_credit_limit > MAX_CNT) ? MAX_CNT : conf_credit_limit;
        slot_free = !out_valid_q || out_ready;
        // rstn gates the grant so in_ready is held low throughout reset.
        grant     = rstn && conf_enable && slot_free && (inflight_q < eff_limit) && (|in_valid);
        in_ready  = grant ? arb_grant : '0;

        sel_addr = '0;
        sel_len  = '0;
        sel_tag  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_addr = in_addr[slice_lo(i, AXI_ADDR_WIDTH) +: AXI_ADDR_WIDTH];
                sel_len  = in_len[slice_lo(i, LEN_WIDTH) +: LEN_WIDTH];
                sel_tag  = in_tag[slice_lo(i, TAG_WIDTH) +: TAG_WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_len_d   = out_len_q;
        out_tag_d   = out_tag_q;
        if (grant) begin
            out_valid_d = 1'b1;
            out_addr_d  = sel_addr;
            out_len_d   = sel_len;
            out_tag_d   = sel_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // A grant and a retirement in the same cycle cancel out.
    always_comb begin
        inflight_d  = inflight_q;
        underflow_d = underflow_q;
        if (grant && !fb_valid) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!grant && fb_valid) begin
            if (inflight_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                inflight_d = inflight_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_len_q   <= '0;
            out_tag_q   <= '0;
            inflight_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_len_q   <= out_len_d;
            out_tag_q   <= out_tag_d;
            inflight_q  <= inflight_d;
            underflow_q <= underflow_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_addr       = out_addr_q;
    assign out_len        = out_len_q;
    assign out_tag        = out_tag_q;
    assign stat_inflight  = inflight_q;
    assign stat_underflow = underflow_q;

endmodule
